// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path.
// Opcodes, functs, ALU commands, FSM states and mux selects.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

endpackage

// File: rtl/mips_mc_control_alu_op_decode.sv
// R-type funct to ALU command translation.
// valid flags the functs the datapath actually supports.
module alu_op_decode
    import mips_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alu_op,
    output logic       valid
);

    // Map funct to ALU command; unknown functs are invalid
    always_comb begin
        alu_op = ALU_ADD;
        valid  = 1'b1;
        unique case (funct)
            FN_ADD:  alu_op = ALU_ADD;
            FN_SUB:  alu_op = ALU_SUB;
            FN_AND:  alu_op = ALU_AND;
            FN_OR:   alu_op = ALU_OR;
            FN_NOR:  alu_op = ALU_NOR;
            FN_SLT:  alu_op = ALU_SLT;
            default: valid  = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_mc_control.sv
// Multicycle MIPS main control FSM.
// Sequences fetch/decode/execute/memory/writeback strobes.
module mips_mc_control
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       i_or_d,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic [3:0] alu_op,
    output logic       instr_done,
    output logic       illegal_op
);

    state_t     state;
    state_t     state_next;
    logic [3:0] fn_alu_op;
    logic       fn_valid;
    logic       op_legal;

    alu_op_decode u_alu_op_decode (
        .funct  (funct),
        .alu_op (fn_alu_op),
        .valid  (fn_valid)
    );

    // State register with synchronous reset to FETCH
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Opcode legality, including the R-type funct check
    always_comb begin
        unique case (opcode)
            OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: op_legal = 1'b1;
            OP_RTYPE: op_legal = fn_valid;
            default:  op_legal = 1'b0;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            S_FETCH: begin
                if (mem_ready) begin
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                state_next = S_FETCH;
                if (op_legal) begin
                    unique case (opcode)
                        OP_LW, OP_SW: state_next = S_MEMADR;
                        OP_RTYPE:     state_next = S_EXEC;
                        OP_BEQ:       state_next = S_BRANCH;
                        OP_J:         state_next = S_JUMP;
                        OP_ADDI:      state_next = S_ADDIEX;
                        default:      state_next = S_FETCH;
                    endcase
                end
            end
            S_MEMADR: begin
                state_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                if (mem_ready) begin
                    state_next = S_MEMWB;
                end
            end
            S_MEMWR: begin
                if (mem_ready) begin
                    state_next = S_FETCH;
                end
            end
            S_EXEC:   state_next = S_ALUWB;
            S_ADDIEX: state_next = S_ADDIWB;
            default:  state_next = S_FETCH;
        endcase
    end

    // Output decode; reset masks strobes and parks selects at FETCH
    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        i_or_d     = 1'b0;
        mem_to_reg = 1'b0;
        reg_dst    = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_B;
        pc_source  = PCSRC_ALU;
        alu_op     = ALU_ADD;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        if (reset) begin
            alu_src_b = SRCB_FOUR;
        end else begin
            unique case (state)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    pc_source = PCSRC_ALU;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: begin
                    alu_src_b  = SRCB_IMM_SH;
                    illegal_op = ~op_legal;
                    instr_done = ~op_legal;
                end
                S_MEMADR, S_ADDIEX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                end
                S_MEMRD: begin
                    i_or_d   = 1'b1;
                    mem_read = 1'b1;
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEMWR: begin
                    i_or_d     = 1'b1;
                    mem_write  = 1'b1;
                    instr_done = mem_ready;
                end
                S_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_B;
                    alu_op    = fn_alu_op;
                end
                S_ALUWB: begin
                    reg_write  = 1'b1;
                    reg_dst    = 1'b1;
                    instr_done = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a  = 1'b1;
                    alu_src_b  = SRCB_B;
                    alu_op     = ALU_SUB;
                    pc_source  = PCSRC_ALUOUT;
                    pc_write   = zero;
                    instr_done = 1'b1;
                end
                S_JUMP: begin
                    pc_source  = PCSRC_JUMP;
                    pc_write   = 1'b1;
                    instr_done = 1'b1;
                end
                S_ADDIWB: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                default: begin
                    alu_op = ALU_ADD;
                end
            endcase
        end
    end

endmodule
